ac97_codec: RTL
===============

# ac97_codec

Codec-side AC97 serial-link responder, clocked from the AC97 bit clock. Detects frame sync, deserializes the controller's output frames into command and DAC slots, and serves a small mixer register file. Serializes return frames on `ac97_sdata_in`: codec-ready tag, read status, ADC PCM. Used as the far end of the link in loopback benches and as a board-less codec stand-in.

## Interface
- `READY_FRAMES`, 2: complete frames after reset before the codec-ready tag asserts.
- `VENDOR_ID1`, 16'h4144: read-only value of register 0x7C.
- `VENDOR_ID2`, 16'h5370: read-only value of register 0x7E.

- `clock` in 1: AC97 bit clock (12.288 MHz); all logic on its rising edge.
- `reset_b` in 1: asynchronous, active-low reset.
- `ac97_synch` in 1: frame sync from the controller.
- `ac97_sdata_out` in 1: controller-to-codec serial data.
- `ac97_sdata_in` out 1: codec-to-controller serial data.
- `adc_left`, `adc_right` in 20: ADC samples returned in slots 3 and 4.
- `adc_valid` in 1: sets tag bits 3 and 4 of the return frame.
- `dac_left`, `dac_right` out 20: last received slot 3 and slot 4 data.
- `dac_tags` out 5: last received slot 0 tag bits 0..4.
- `dac_strobe` out 1: one-cycle pulse when `dac_*` update.
- `frame_err` out 1: one-cycle pulse on a truncated frame.
- `codec_ready` out 1: mirrors the ready tag.
- `hp_vol`, `pcm_vol`, `mic_vol`, `rec_select`, `rec_gain` out 16 each: live contents of registers 0x04, 0x18, 0x0E, 0x1A and 0x1C.

## Operation
- **Sync detection:** `ac97_synch` is registered each edge. The edge where the registered synch goes 0→1 is E0, and the frame position counter `pos` is set to 0. `pos` increments each edge and saturates at 256, which is the idle state.
- **Receive:** the `ac97_sdata_out` sample taken at edge E(k+1) is frame bit k, k = 0..255, MSB first.
  - Slot 0: bits 0–15.
  - Slot 1: bits 16–35; the command address is bits 16–23.
  - Slot 2: bits 36–55; the command data is bits 36–51.
  - Slot 3: bits 56–75.
  - Slot 4: bits 76–95.
- **Command decode** at E56, executed only if tags 1 and 2 are both set:
  - Address bit 7 = 1 is a read. Latch `addr[6:0]` and mark a status pending for the next frame.
  - Otherwise it is a write to a writable register. Writes to 0x7C/0x7E or unmapped addresses are ignored.
  - A write to 0x00 restores every register to its default.
- **Register map and defaults:**
  - 0x02 = 8000.
  - 0x04 = 8000.
  - 0x0A = 0000.
  - 0x0E = 8008.
  - 0x18 = 8808.
  - 0x1A = 0000.
  - 0x1C = 8000.
  - 0x20 = 0000.
  - 0x7C = VENDOR_ID1, 0x7E = VENDOR_ID2.
  - Reads of 0x00 and unmapped addresses return 0000.
- **DAC output:** at E96, `dac_left`, `dac_right` and `dac_tags` update and `dac_strobe` pulses, regardless of the valid tags.
- **Ready tag:** a frame counts as complete when `pos` reaches 255. After READY_FRAMES complete frames, `codec_ready` is set and stays 1 until reset.
- **Transmit:** frame bit k is launched on E_k and held until E(k+1).
  - Slot 0, bits 0–4: {`codec_ready`, pending, pending, `adc_valid`, `adc_valid`}; remaining tag bits are 0.
  - Slot 1: {read addr, 12'h000}.
  - Slot 2: {read data, 4'h0}.
  - Slots 3 and 4: ADC data, latched at E0.
  - All other bits are 0. Slots 1 and 2 are all 0 when nothing is pending.
- **Status pending:** pending is consumed when slot 2 finishes transmitting at E56. A read decoded at E56 of the same frame sets it for the following frame, so read data returns exactly one frame after the command.
- **Truncated frame:** a sync rise while 1 ≤ `pos` < 255 pulses `frame_err` and restarts at E0.
  - The partial frame produces no `dac_strobe` if the restart comes before E96.
  - The partial frame's command is discarded if the restart comes before E56.
  - A pending status survives.
- **Idle:** in the idle state, `ac97_sdata_in` is held at 0.

## Timing
- **Reset values:**
  - `ac97_sdata_in`, `dac_*`, `dac_strobe`, `frame_err` and `codec_ready` are 0.
  - Registers take their defaults.
  - `pos` is idle and pending is cleared.
- **Reset mid-frame** aborts immediately. The next sync rise starts a fresh frame.
- **Latency:** a DAC sample is out 96 edges after E0. A read returns in slot 2 of the frame after the command frame.
- **Write visibility:** a register write is visible on its output port from the edge after E56.
- **Simultaneous events:** a write to 0x00 and a read of any register in the same frame returns post-reset contents.

## Configuration
- `AC97_CODEC_LOOPBACK_EN` defined: slots 3 and 4 transmit the `dac_left`/`dac_right` values latched at E0, i.e. the previous frame's received data. Tags 3 and 4 equal the received tags 3 and 4. `adc_*` inputs are ignored.
- Undefined: slots 3, 4 and tags 3, 4 come from `adc_left`, `adc_right` and `adc_valid`.

## Test plan
- Reset, then clean 256-bit frames with no commands → `codec_ready`=0 during frames 1–2 and tag bit 0 = 1 from frame 3 on; all status slots are 0.
- Frame writing 0x04 = 0x0808 → `hp_vol`=0x0808 from E57; a read of 0x84 next frame → the following frame returns slot 1 = 0x04000 and slot 2 = 0x08080 with tags 1 and 2 set.
- Read 0xFC → next frame slot 2 = {VENDOR_ID2, 4'h0} = 0x53700; write 0x7C = 0x1234 → no change on readback.
- Slot 3 = 0xABCDE and slot 4 = 0x12345 with tags 3 and 4 → `dac_strobe` at E96 with `dac_left`=0xABCDE, `dac_right`=0x12345, `dac_tags`=5'b11111.
- Sync rise at `pos`=70 → `frame_err` pulse, no `dac_strobe`; the next full frame decodes correctly.
- With AC97_CODEC_LOOPBACK_EN defined: DAC left 0x55555 in frame N → slot 3 of frame N+1 = 0x55555; `reset_b` low mid-frame → `ac97_sdata_in`=0 immediately and registers return to defaults.

Source files
------------

// File: rtl/ac97_codec.sv
// Codec-side AC97 link responder: frame sync, slot deserializer, mixer register file, return-frame serializer.
// Build option: AC97_CODEC_LOOPBACK_EN sends the previously received DAC slots back in place of the ADC inputs.
module ac97_codec #(
  parameter int          READY_FRAMES = 2,
  parameter logic [15:0] VENDOR_ID1   = 16'h4144,
  parameter logic [15:0] VENDOR_ID2   = 16'h5370
) (
  input  logic        clock,
  input  logic        reset_b,
  input  logic        ac97_synch,
  input  logic        ac97_sdata_out,
  output logic        ac97_sdata_in,
  input  logic [19:0] adc_left,
  input  logic [19:0] adc_right,
  input  logic        adc_valid,
  output logic [19:0] dac_left,
  output logic [19:0] dac_right,
  output logic [4:0]  dac_tags,
  output logic        dac_strobe,
  output logic        frame_err,
  output logic        codec_ready,
  output logic [15:0] hp_vol,
  output logic [15:0] pcm_vol,
  output logic [15:0] mic_vol,
  output logic [15:0] rec_select,
  output logic [15:0] rec_gain
);

  localparam logic [15:0] DEF_02 = 16'h8000;
  localparam logic [15:0] DEF_04 = 16'h8000;
  localparam logic [15:0] DEF_0A = 16'h0000;
  localparam logic [15:0] DEF_0E = 16'h8008;
  localparam logic [15:0] DEF_18 = 16'h8808;
  localparam logic [15:0] DEF_1A = 16'h0000;
  localparam logic [15:0] DEF_1C = 16'h8000;
  localparam logic [15:0] DEF_20 = 16'h0000;
  localparam logic [8:0]  READY_CNT = 9'(READY_FRAMES);
  localparam logic [8:0]  POS_IDLE  = 9'd256;

  logic        r_synch;
  logic [8:0]  r_pos;
  logic [19:0] r_sh;
  logic [4:0]  r_rx_tags;
  logic [7:0]  r_addr;
  logic [19:0] r_slot3;
  logic [19:0] r_dac_l;
  logic [19:0] r_dac_r;
  logic [4:0]  r_dac_tags;
  logic        r_dac_strobe;
  logic        r_frame_err;
  logic [7:0]  r_frames;
  logic        r_ready;
  logic        r_pend;
  logic [6:0]  r_rd_addr;
  logic [15:0] r_rd_data;
  logic [19:0] r_tx_l;
  logic [19:0] r_tx_r;
  logic        r_tx_v3;
  logic        r_tx_v4;
  logic        r_sdin;
  logic [15:0] r_reg02, r_reg04, r_reg0a, r_reg0e, r_reg18, r_reg1a, r_reg1c, r_reg20;

  logic        w_rise;
  logic        w_active;
  logic        w_step;
  logic [19:0] w_sh_next;
  logic        w_cmd_edge;
  logic        w_cmd_ok;
  logic [15:0] w_wdata;
  logic [15:0] w_rd_mux;
  logic [95:0] w_tx_frame;
  logic [8:0]  w_tx_idx;
  logic        w_tx_bit;

  assign w_rise     = ac97_synch & ~r_synch;
  assign w_active   = ~r_pos[8];
  assign w_step     = w_active & ~w_rise;
  assign w_sh_next  = {r_sh[18:0], ac97_sdata_out};
  // Slot 2 completes on the edge that samples frame bit 55 (pos 55).
  assign w_cmd_edge = w_step && (r_pos == 9'd55);
  assign w_cmd_ok   = w_cmd_edge && r_rx_tags[3] && r_rx_tags[2];
  assign w_wdata    = w_sh_next[19:4];

  always_comb begin
    w_rd_mux = 16'h0000;
    case (r_addr[6:0])
      7'h02:   w_rd_mux = r_reg02;
      7'h04:   w_rd_mux = r_reg04;
      7'h0A:   w_rd_mux = r_reg0a;
      7'h0E:   w_rd_mux = r_reg0e;
      7'h18:   w_rd_mux = r_reg18;
      7'h1A:   w_rd_mux = r_reg1a;
      7'h1C:   w_rd_mux = r_reg1c;
      7'h20:   w_rd_mux = r_reg20;
      7'h7C:   w_rd_mux = VENDOR_ID1;
      7'h7E:   w_rd_mux = VENDOR_ID2;
      default: w_rd_mux = 16'h0000;
    endcase
  end

  // Index of the bit launched on this edge; anything past slot 4 (and idle) sends 0.
  always_comb begin
    w_tx_frame = {r_ready, r_pend, r_pend, r_tx_v3, r_tx_v4, 11'h000,
                  r_pend ? {1'b0, r_rd_addr, 12'h000} : 20'h00000,
                  r_pend ? {r_rd_data, 4'h0} : 20'h00000,
                  r_tx_l, r_tx_r};
    w_tx_idx   = w_rise ? 9'd0 : r_pos + 9'd1;
    w_tx_bit   = 1'b0;
    if (w_tx_idx < 9'd96) w_tx_bit = w_tx_frame[7'd95 - w_tx_idx[6:0]];
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      r_synch      <= 1'b0;
      r_pos        <= POS_IDLE;
      r_sh         <= '0;
      r_rx_tags    <= '0;
      r_addr       <= '0;
      r_slot3      <= '0;
      r_dac_l      <= '0;
      r_dac_r      <= '0;
      r_dac_tags   <= '0;
      r_dac_strobe <= 1'b0;
      r_frame_err  <= 1'b0;
      r_frames     <= '0;
      r_ready      <= 1'b0;
      r_pend       <= 1'b0;
      r_rd_addr    <= '0;
      r_rd_data    <= '0;
      r_tx_l       <= '0;
      r_tx_r       <= '0;
      r_tx_v3      <= 1'b0;
      r_tx_v4      <= 1'b0;
      r_sdin       <= 1'b0;
    end else begin
      r_synch      <= ac97_synch;
      r_dac_strobe <= 1'b0;
      r_frame_err  <= w_rise && (r_pos != 9'd0) && (r_pos < 9'd255);
      r_sdin       <= w_tx_bit;
      if (w_rise) r_pos <= 9'd0;
      else if (w_active) r_pos <= r_pos + 9'd1;
      if (w_rise) begin
`ifdef AC97_CODEC_LOOPBACK_EN
        r_tx_l  <= r_dac_l;
        r_tx_r  <= r_dac_r;
        r_tx_v3 <= r_dac_tags[1];
        r_tx_v4 <= r_dac_tags[0];
`else
        r_tx_l  <= adc_left;
        r_tx_r  <= adc_right;
        r_tx_v3 <= adc_valid;
        r_tx_v4 <= adc_valid;
`endif
      end
      if (w_step) begin
        r_sh <= w_sh_next;
        case (r_pos)
          9'd15:  r_rx_tags <= w_sh_next[15:11];
          9'd35:  r_addr <= w_sh_next[19:12];
          9'd75:  r_slot3 <= w_sh_next;
          9'd95: begin
            r_dac_l      <= r_slot3;
            r_dac_r      <= w_sh_next;
            r_dac_tags   <= r_rx_tags;
            r_dac_strobe <= 1'b1;
          end
          9'd254: begin
            if (r_frames != 8'hFF) r_frames <= r_frames + 8'd1;
            if ({1'b0, r_frames} + 9'd1 >= READY_CNT) r_ready <= 1'b1;
          end
          default: ;
        endcase
      end
      // The status just sent is retired here; a read in this frame arms the next one.
      if (w_cmd_edge) begin
        r_pend <= w_cmd_ok && r_addr[7];
        if (w_cmd_ok && r_addr[7]) begin
          r_rd_addr <= r_addr[6:0];
          r_rd_data <= w_rd_mux;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      r_reg02 <= DEF_02;
      r_reg04 <= DEF_04;
      r_reg0a <= DEF_0A;
      r_reg0e <= DEF_0E;
      r_reg18 <= DEF_18;
      r_reg1a <= DEF_1A;
      r_reg1c <= DEF_1C;
      r_reg20 <= DEF_20;
    end else if (w_cmd_ok && !r_addr[7]) begin
      case (r_addr[6:0])
        7'h00: begin
          r_reg02 <= DEF_02;
          r_reg04 <= DEF_04;
          r_reg0a <= DEF_0A;
          r_reg0e <= DEF_0E;
          r_reg18 <= DEF_18;
          r_reg1a <= DEF_1A;
          r_reg1c <= DEF_1C;
          r_reg20 <= DEF_20;
        end
        7'h02:   r_reg02 <= w_wdata;
        7'h04:   r_reg04 <= w_wdata;
        7'h0A:   r_reg0a <= w_wdata;
        7'h0E:   r_reg0e <= w_wdata;
        7'h18:   r_reg18 <= w_wdata;
        7'h1A:   r_reg1a <= w_wdata;
        7'h1C:   r_reg1c <= w_wdata;
        7'h20:   r_reg20 <= w_wdata;
        default: ;
      endcase
    end
  end

  assign ac97_sdata_in = r_sdin;
  assign dac_left      = r_dac_l;
  assign dac_right     = r_dac_r;
  assign dac_tags      = r_dac_tags;
  assign dac_strobe    = r_dac_strobe;
  assign frame_err     = r_frame_err;
  assign codec_ready   = r_ready;
  assign hp_vol        = r_reg04;
  assign pcm_vol       = r_reg18;
  assign mic_vol       = r_reg0e;
  assign rec_select    = r_reg1a;
  assign rec_gain      = r_reg1c;

endmodule
